// File: rtl/ray_packet_assembler_if.sv
// Bus bundle between the ray generation stage, the packet assembler and the
// downstream traversal stage: push side, packet handshake and FIFO status.
interface ray_packet_assembler_if #(
  parameter int WORD_WIDTH    = 32,
  parameter int DEPTH         = 16,
  parameter int WORDS_PER_RAY = 9
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                                iEnable;
  logic                                iClear;
  logic                                iPush;
  logic [WORD_WIDTH-1:0]               iData;
  logic                                oFull;
  logic [CW-1:0]                       oCount;
  logic                                oOverflow;
  logic                                oRayValid;
  logic                                iRayReady;
  logic [WORDS_PER_RAY*WORD_WIDTH-1:0] oRayData;

  // Assembler side
  modport slave (
    input  iEnable, iClear, iPush, iData, iRayReady,
    output oFull, oCount, oOverflow, oRayValid, oRayData
  );

  // Producer / consumer side
  modport master (
    output iEnable, iClear, iPush, iData, iRayReady,
    input  oFull, oCount, oOverflow, oRayValid, oRayData
  );
endinterface

// File: rtl/ray_packet_assembler.sv
// Ray packet assembler: a word FIFO fed by the ray generation stage, drained
// one word per cycle into a WORDS_PER_RAY-word packet that is held until the
// traversal stage accepts it. Words pass through untouched.
module ray_packet_assembler #(
  parameter int WORD_WIDTH    = 32,
  parameter int DEPTH         = 16,
  parameter int WORDS_PER_RAY = 9
) (
  input  logic                   iClock,
  input  logic                   iReset,
  ray_packet_assembler_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (WORDS_PER_RAY > 1) ? $clog2(WORDS_PER_RAY) : 1;
  localparam int PW = WORDS_PER_RAY * WORD_WIDTH;

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [IW-1:0] IDX_LAST_C = IW'(WORDS_PER_RAY - 1);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  valid_q, valid_d;
  logic [PW-1:0]         ray_q, ray_d;
  logic [WORD_WIDTH-1:0] mem_q [DEPTH];

  logic                  full_s;
  logic                  push_ok_s;
  logic                  pop_s;
  logic [WORD_WIDTH-1:0] head_s;

  // FIFO status and the push/pop decisions taken from pre-edge state
  always_comb begin
    full_s    = (count_q == DEPTH_C);
    push_ok_s = bus.iPush && !full_s;
    pop_s     = (state_q == COLLECT) && bus.iEnable && (count_q != CW'(0));
    head_s    = mem_q[rd_ptr_q];
  end

  // Next-state logic for FIFO pointers, occupancy, packet FSM and packet slots
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    valid_d    = valid_q;
    ray_d      = ray_q;

    if (bus.iClear) begin
      // Flush wins over any push or pop this cycle
      state_d    = COLLECT;
      idx_d      = IW'(0);
      wr_ptr_d   = AW'(0);
      rd_ptr_d   = AW'(0);
      count_d    = CW'(0);
      overflow_d = 1'b0;
      valid_d    = 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else if (bus.iPush) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end

      case ({push_ok_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      case (state_q)
        COLLECT: begin
          if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            for (int k = 0; k < WORDS_PER_RAY; k++) begin
              if (idx_q == IW'(k)) begin
                ray_d[k*WORD_WIDTH +: WORD_WIDTH] = head_s;
              end else begin
                ray_d[k*WORD_WIDTH +: WORD_WIDTH] = ray_q[k*WORD_WIDTH +: WORD_WIDTH];
              end
            end
            if (idx_q == IDX_LAST_C) begin
              idx_d   = IW'(0);
              state_d = HOLD;
              valid_d = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            idx_d = idx_q;
          end
        end
        HOLD: begin
          // Packet stays put until the traversal stage takes it
          if (bus.iRayReady) begin
            state_d = COLLECT;
            valid_d = 1'b0;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = COLLECT;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // Control and packet registers with asynchronous reset
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q    <= COLLECT;
      idx_q      <= IW'(0);
      wr_ptr_q   <= AW'(0);
      rd_ptr_q   <= AW'(0);
      count_q    <= CW'(0);
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      ray_q      <= PW'(0);
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      ray_q      <= ray_d;
    end
  end

  // FIFO storage write; contents are don't-care after reset or flush
  always_ff @(posedge iClock) begin
    if (push_ok_s && !bus.iClear) begin
      mem_q[wr_ptr_q] <= bus.iData;
    end
  end

  assign bus.oFull     = full_s;
  assign bus.oCount    = count_q;
  assign bus.oOverflow = overflow_q;
  assign bus.oRayValid = valid_q;
  assign bus.oRayData  = ray_q;
endmodule

// File: tb/tb_ray_packet_assembler.sv
// Self-checking bench for ray_packet_assembler: a queue-based model checked
// every cycle plus hand-computed directed expectations.
module tb_ray_packet_assembler;
  localparam int W   = 32;
  localparam int D   = 16;
  localparam int WPR = 9;
  localparam int PW  = W * WPR;

  logic iClock = 1'b0;
  logic rst_n;

  ray_packet_assembler_if #(.WORD_WIDTH(W), .DEPTH(D), .WORDS_PER_RAY(WPR)) bus ();

  ray_packet_assembler #(.WORD_WIDTH(W), .DEPTH(D), .WORDS_PER_RAY(WPR)) dut (
    .iClock (iClock),
    .iReset (rst_n),
    .bus    (bus.slave)
  );

  always #5 iClock = ~iClock;

  int total = 0;
  int bad   = 0;

  // Behavioural model: FIFO queue, partial packet, held packet, flags
  logic [W-1:0]  mq[$];
  logic [W-1:0]  part[$];
  logic [PW-1:0] pkt_log[$];
  logic [PW-1:0] mpkt = '0;
  bit            mvalid = 1'b0;
  bit            movf   = 1'b0;

  function automatic logic [W-1:0] wd(input logic [PW-1:0] p, input int k);
    return p[k*W +: W];
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model update from the pre-edge inputs and model state
  always @(posedge iClock or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete(); part.delete(); mvalid = 1'b0; movf = 1'b0;
    end else if (bus.iClear) begin
      mq.delete(); part.delete(); mvalid = 1'b0; movf = 1'b0;
    end else begin
      bit was_full;
      was_full = (mq.size() == D);
      if (!mvalid && bus.iEnable && mq.size() > 0) begin
        part.push_back(mq.pop_front());
        if (part.size() == WPR) begin
          for (int k = 0; k < WPR; k++) mpkt[k*W +: W] = part[k];
          mvalid = 1'b1;
          pkt_log.push_back(mpkt);
          part.delete();
        end
      end else if (mvalid && bus.iRayReady) begin
        mvalid = 1'b0;
      end
      if (bus.iPush) begin
        if (was_full) movf = 1'b1;
        else          mq.push_back(bus.iData);
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge iClock) begin
    if (rst_n === 1'b1) begin
      check("count",    64'(bus.oCount),    64'(mq.size()));
      check("full",     64'(bus.oFull),     64'(mq.size() == D));
      check("overflow", 64'(bus.oOverflow), 64'(movf));
      check("valid",    64'(bus.oRayValid), 64'(mvalid));
      if (mvalid) begin
        total++;
        if (bus.oRayData !== mpkt) begin
          bad++;
          $display("FAIL raydata: got %0h expected %0h", bus.oRayData, mpkt);
        end
      end
    end
  end

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] d);
    bus.iPush = 1'b1; bus.iData = d;
    step();
    bus.iPush = 1'b0;
  endtask

  task automatic do_clear();
    bus.iClear = 1'b1;
    step();
    bus.iClear = 1'b0;
  endtask

  int base;
  int n;
  logic [PW-1:0] saved;
  logic [W-1:0]  seq;

  initial begin
    bus.iEnable = 1'b1; bus.iClear = 1'b0; bus.iPush = 1'b0;
    bus.iData = '0; bus.iRayReady = 1'b1;
    rst_n = 1'b0;
    #12;
    check("rst_count", 64'(bus.oCount), 64'd0);
    check("rst_full",  64'(bus.oFull), 64'd0);
    check("rst_ovf",   64'(bus.oOverflow), 64'd0);
    check("rst_valid", 64'(bus.oRayValid), 64'd0);
    check("rst_data",  64'(bus.oRayData == '0), 64'd1);
    rst_n = 1'b1;
    step();

    // T1: nine consecutive pushes, valid one edge after the last push
    base = pkt_log.size();
    for (int i = 1; i <= 9; i++) push_word(W'(i));
    check("t1_not_yet", 64'(bus.oRayValid), 64'd0);
    step();
    check("t1_valid", 64'(bus.oRayValid), 64'd1);
    check("t1_w0", 64'(wd(bus.oRayData, 0)), 64'h1);
    check("t1_w8", 64'(wd(bus.oRayData, 8)), 64'h9);
    step();
    check("t1_pulse", 64'(bus.oRayValid), 64'd0);

    // T2: overflow with pops disabled, then drain
    do_clear();
    bus.iEnable = 1'b0;
    for (int i = 1; i <= 17; i++) push_word(W'(i));
    check("t2_count", 64'(bus.oCount), 64'd16);
    check("t2_full",  64'(bus.oFull), 64'd1);
    check("t2_ovf",   64'(bus.oOverflow), 64'd1);
    base = pkt_log.size();
    bus.iEnable = 1'b1;
    for (int i = 0; i < 30; i++) step();
    push_word(W'(32'h20));
    push_word(W'(32'h21));
    for (int i = 0; i < 5; i++) step();
    check("t2_npkt", 64'(pkt_log.size() - base), 64'd2);
    if (pkt_log.size() >= base + 2) begin
      check("t2_p0w0", 64'(wd(pkt_log[base], 0)), 64'h1);
      check("t2_p1w0", 64'(wd(pkt_log[base+1], 0)), 64'hA);
      check("t2_p1w6", 64'(wd(pkt_log[base+1], 6)), 64'h10);
      check("t2_p1w7", 64'(wd(pkt_log[base+1], 7)), 64'h20);
    end

    // T3: hold with ready low while more words arrive
    do_clear();
    check("t3_ovf_cleared", 64'(bus.oOverflow), 64'd0);
    bus.iRayReady = 1'b0;
    for (int i = 0; i < 9; i++) push_word(W'(32'h100 + i));
    step();
    check("t3_valid", 64'(bus.oRayValid), 64'd1);
    saved = bus.oRayData;
    for (int i = 0; i < 9; i++) push_word(W'(32'h200 + i));
    check("t3_count", 64'(bus.oCount), 64'd9);
    check("t3_stable", 64'(bus.oRayData == saved), 64'd1);
    check("t3_w0", 64'(wd(bus.oRayData, 0)), 64'h100);
    bus.iRayReady = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.oRayValid === 1'b1) begin n = i; break; end
    end
    check("t3_cycles", 64'(n), 64'd10);
    check("t3_p2w0", 64'(wd(bus.oRayData, 0)), 64'h200);

    // T4: push every cycle across pointer wrap, order preserved
    do_clear();
    bus.iEnable = 1'b0;
    seq = W'(32'h500);
    for (int i = 0; i < 4; i++) begin push_word(seq); seq = seq + W'(1); end
    bus.iEnable = 1'b1;
    base = pkt_log.size();
    for (int i = 0; i < 40; i++) begin push_word(seq); seq = seq + W'(1); end
    for (int i = 0; i < 20; i++) step();
    check("t4_ovf", 64'(bus.oOverflow), 64'd0);
    check("t4_npkt", 64'(pkt_log.size() - base), 64'd4);
    if (pkt_log.size() >= base + 4) begin
      check("t4_first", 64'(wd(pkt_log[base], 0)), 64'h500);
      for (int p = 0; p < 4; p++)
        for (int k = 0; k < WPR; k++)
          check("t4_order", 64'(wd(pkt_log[base+p], k)), 64'(32'h500 + p*WPR + k));
    end

    // T5a: asynchronous reset mid-packet
    do_clear();
    for (int i = 0; i < 5; i++) push_word(W'(32'h600 + i));
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_count", 64'(bus.oCount), 64'd0);
    check("t5_rst_valid", 64'(bus.oRayValid), 64'd0);
    check("t5_rst_ovf",   64'(bus.oOverflow), 64'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) push_word(W'(32'h300 + i));
    step();
    check("t5_rst_valid2", 64'(bus.oRayValid), 64'd1);
    check("t5_rst_w0", 64'(wd(bus.oRayData, 0)), 64'h300);
    step();

    // T5b: synchronous clear mid-packet, with a push in the clear cycle
    for (int i = 0; i < 5; i++) push_word(W'(32'h700 + i));
    bus.iPush = 1'b1; bus.iData = W'(32'hBAD);
    do_clear();
    bus.iPush = 1'b0;
    check("t5_clr_count", 64'(bus.oCount), 64'd0);
    check("t5_clr_valid", 64'(bus.oRayValid), 64'd0);
    for (int i = 0; i < 9; i++) push_word(W'(32'h400 + i));
    step();
    check("t5_clr_valid2", 64'(bus.oRayValid), 64'd1);
    check("t5_clr_w0", 64'(wd(bus.oRayData, 0)), 64'h400);
    check("t5_clr_w8", 64'(wd(bus.oRayData, 8)), 64'h408);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
